mem_readback_streamer: RTL

- Reader/sequencer for the block-RAM `memory` module's read port (raddr/dout). On `start`, it sweeps a contiguous address range and honours the one-cycle read latency.
- It packs WID_MEM-wide words into OUT_W-wide beats and streams them out on a valid/ready interface. It also accumulates a checksum.
- Purpose: read back memory contents after a bitstream reinit, so they can be compared against the init file.
- Sits beside `memory` in the top level. It owns `raddr`; the write port stays with the loader.

---
 rtl/mem_readback_streamer_pkg.sv | 10 +
 rtl/mem_readback_streamer_if.sv | 9 +
 rtl/mem_readback_streamer_word_packer.sv | 42 ++++
 rtl/mem_readback_streamer.sv | 80 ++++++++
 4 files changed

// File: rtl/mem_readback_streamer_pkg.sv
// mem_rb_pkg: FSM state type and beat sizing helpers shared by the readback streamer files
package mem_rb_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic int words_per_beat(input int out_w, input int wid_mem);
    return out_w / wid_mem;
  endfunction
  function automatic bit beat_fits(input int out_w, input int wid_mem);
    return (out_w % wid_mem == 0) && (out_w >= wid_mem);
  endfunction
endpackage

// File: rtl/mem_readback_streamer_if.sv
// mem_readback_streamer_if: packed beat stream with valid/ready handshake
interface mem_readback_streamer_if #(parameter int OUT_W = 8);
  logic [OUT_W-1:0] m_data;
  logic m_valid;
  logic m_ready;
  logic m_last;
  modport master(output m_data, m_valid, m_last, input m_ready);
  modport slave(input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/mem_readback_streamer_word_packer.sv
// word_packer: gathers words into an N-slot beat and hands it to a valid/ready output register
module word_packer
  import mem_rb_pkg::*;
#(
  parameter int WID_MEM = 1,
  parameter int OUT_W = 8,
  localparam int N = words_per_beat(OUT_W, WID_MEM),
  localparam int CW = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               w_valid,
  input  logic [WID_MEM-1:0] word,
  input  logic               flush,
  input  logic               last,
  output logic [CW-1:0]      cnt,
  output logic               load,
  mem_readback_streamer_if.master m
);
  logic [OUT_W-1:0] acc, nxt_acc;
  logic [CW-1:0] nxt_cnt;
  // the arriving word joins the beat it completes, so a full beat leaves the same cycle it fills
  assign nxt_acc = w_valid ? acc | (OUT_W'(word) << (WID_MEM * cnt)) : acc;
  assign nxt_cnt = cnt + CW'(w_valid);
  assign load = (!m.m_valid || m.m_ready) && (nxt_cnt == CW'(N) || (flush && nxt_cnt != '0));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc <= '0;
      cnt <= '0;
      m.m_data <= '0;
      m.m_valid <= 1'b0;
      m.m_last <= 1'b0;
    end else begin
      acc <= load ? '0 : nxt_acc;
      cnt <= load ? '0 : nxt_cnt;
      m.m_valid <= load || (m.m_valid && !m.m_ready);
      if (load) begin
        m.m_data <= nxt_acc;
        m.m_last <= last;
      end
    end
endmodule

// File: rtl/mem_readback_streamer.sv
// mem_readback_streamer: sweeps a block-RAM address range, packs words into beats and sums them
module mem_readback_streamer
  import mem_rb_pkg::*;
#(
  parameter int WID_MEM = 1,
  parameter int EXP_MEM = 16,
  parameter int DEPTH_MEM = 2 ** EXP_MEM,
  parameter int OUT_W = 8,
  parameter int CSUM_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [EXP_MEM-1:0] base_addr,
  input  logic [EXP_MEM:0]   length,
  output logic [EXP_MEM-1:0] raddr,
  input  logic [WID_MEM-1:0] mem_dout,
  mem_readback_streamer_if.master m,
  output logic               busy,
  output logic               done,
  output logic [CSUM_W-1:0]  checksum
);
  localparam int N = words_per_beat(OUT_W, WID_MEM);
  localparam int CW = $clog2(N + 1);
  if (!beat_fits(OUT_W, WID_MEM) || DEPTH_MEM != 2 ** EXP_MEM) begin : g_cfg_bad
    $error("mem_readback_streamer: OUT_W must be a multiple of WID_MEM and DEPTH_MEM must be 2**EXP_MEM");
  end
  state_t state, nxt;
  logic [EXP_MEM-1:0] base;
  logic [EXP_MEM:0] len, issued;
  logic [CW-1:0] cnt;
  logic p, issue, load, all_issued;
  assign all_issued = issued == len;
  // a slot must stay free for the word still in flight unless a beat leaves this cycle
  assign issue = state == RUN && !all_issued && ((cnt + CW'(p) < CW'(N)) || load);
  assign raddr = base + issued[EXP_MEM-1:0];
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = length == '0 ? DONE : RUN;
      RUN: if (issue && issued + (EXP_MEM+1)'(1) == len) nxt = DRAIN;
      DRAIN: if (m.m_valid && m.m_ready && m.m_last) nxt = DONE;
      DONE: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      base <= '0;
      len <= '0;
      issued <= '0;
      p <= 1'b0;
      checksum <= '0;
    end else begin
      state <= nxt;
      p <= issue;
      if (state == IDLE && start) begin
        base <= base_addr;
        len <= length;
        issued <= '0;
        checksum <= '0;
      end else begin
        if (issue) issued <= issued + (EXP_MEM+1)'(1);
        if (p) checksum <= checksum + CSUM_W'(mem_dout);
      end
    end
  word_packer #(.WID_MEM(WID_MEM), .OUT_W(OUT_W)) u_packer (
    .clk(clk),
    .reset(reset),
    .w_valid(p),
    .word(mem_dout),
    .flush(all_issued),
    .last(all_issued),
    .cnt(cnt),
    .load(load),
    .m(m)
  );
endmodule
